// File: rtl/mem_bist_master_if.sv
// Single-port synchronous memory bus driven by the BIST master.
// rdata is registered inside the memory and valid the cycle after rd_en.
interface mem_bist_master_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output addr, rd_en, wr_en, wdata, input rdata);
  modport slave  (input addr, rd_en, wr_en, wdata, output rdata);
endinterface

// File: rtl/mem_bist_master.sv
// March-test BIST engine: W0 up, (r P, w ~P) up, (r ~P, w P) down, r P up.
// Reports pass, saturating mismatch count and the first failing address.
module mem_bist_master #(
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = '0,
  parameter int unsigned           CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  mem_bist_master_if.master     mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CntOne   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CntMax   = '1;

  typedef enum logic [3:0] {
    StIdle, StW0, StARd, StAWr, StDRd, StDWr, StR0, StDrain, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;
  logic [ADDR_WIDTH-1:0] first_fail_q, first_fail_d;
  // Compare pipeline: tracks the read issued last cycle, whose data arrives now.
  logic                  cmp_valid_q, cmp_valid_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
  logic                  mismatch;

  assign mismatch = cmp_valid_q && (mem.rdata != cmp_exp_q);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    cmp_valid_d  = rd_en_q;
    cmp_addr_d   = addr_q;
    cmp_exp_d    = (state_q == StDRd) ? ~PATTERN : PATTERN;

    if (mismatch) begin
      if (fail_count_q != CntMax) begin
        fail_count_d = fail_count_q + CntOne;
      end
      // Count never returns to zero once saturated, so zero means "no failure yet".
      if (fail_count_q == '0) begin
        first_fail_d = cmp_addr_q;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StW0;
          addr_d       = '0;
          fail_count_d = '0;
          first_fail_d = '0;
        end
      end
      StW0: begin
        if (addr_q == LastAddr) begin
          state_d = StARd;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AddrOne;
        end
      end
      StARd: state_d = StAWr;
      StAWr: begin
        if (addr_q == LastAddr) begin
          state_d = StDRd;
        end else begin
          state_d = StARd;
          addr_d  = addr_q + AddrOne;
        end
      end
      StDRd: state_d = StDWr;
      StDWr: begin
        if (addr_q == '0) begin
          state_d = StR0;
        end else begin
          state_d = StDRd;
          addr_d  = addr_q - AddrOne;
        end
      end
      StR0: begin
        if (addr_q == LastAddr) begin
          state_d = StDrain;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AddrOne;
        end
      end
      StDrain: state_d = StDone;
      default: begin
        state_d = StIdle;
        addr_d  = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    rd_en_d = (state_d == StARd) || (state_d == StDRd) || (state_d == StR0);
    wr_en_d = (state_d == StW0) || (state_d == StAWr) || (state_d == StDWr);
    if (state_d == StAWr) begin
      wdata_d = ~PATTERN;
    end else if (wr_en_d) begin
      wdata_d = PATTERN;
    end else begin
      wdata_d = '0;
    end
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
    pass_d = (state_d == StDone) && (fail_count_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= '0;
      first_fail_q <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_addr_q   <= '0;
      cmp_exp_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_addr_q   <= cmp_addr_d;
      cmp_exp_q    <= cmp_exp_d;
    end
  end

  assign mem.addr        = addr_q;
  assign mem.rd_en       = rd_en_q;
  assign mem.wr_en       = wr_en_q;
  assign mem.wdata       = wdata_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail_count      = fail_count_q;
  assign first_fail_addr = first_fail_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: behavioural memory with injectable faults and a
// scoreboard of the expected March bus sequence.
module tb_mem_bist_master;
  localparam int          N = 16;
  localparam logic [15:0] P = 16'h0000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [7:0] fail_count;
  logic [3:0] first_fail_addr;

  mem_bist_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

  mem_bist_master #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .PATTERN(P), .CNT_WIDTH(8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .mem             (bus),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] wdata;
  } op_t;

  op_t         exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          fault_mode = 0;  // 0 none, 1 bit0 SA1 @5, 2 bit15 SA0 @9, 3 addr 11 -> 3
  int          excl_viol = 0;
  logic [15:0] mem_arr [16];

  function automatic logic [3:0] phys(input logic [3:0] a);
    return (fault_mode == 3 && a == 4'd11) ? 4'd3 : a;
  endfunction

  function automatic logic [15:0] corrupt(input logic [3:0] a, input logic [15:0] d);
    if (fault_mode == 1 && a == 4'd5) return d | 16'h0001;
    if (fault_mode == 2 && a == 4'd9) return d & 16'h7fff;
    return d;
  endfunction

  always @(posedge clk) begin
    if (bus.wr_en) mem_arr[phys(bus.addr)] <= bus.wdata;
    if (bus.rd_en) bus.rdata <= corrupt(phys(bus.addr), mem_arr[phys(bus.addr)]);
  end

  always @(negedge clk) begin
    if (bus.rd_en === 1'b1 && bus.wr_en === 1'b1) excl_viol++;
  end

  task automatic push_march();
    op_t op;
    for (int i = 0; i < N; i++) begin
      op = '{rd: 1'b0, wr: 1'b1, addr: 4'(i), wdata: P};
      exp_q.push_back(op);
    end
    for (int i = 0; i < N; i++) begin
      op = '{rd: 1'b1, wr: 1'b0, addr: 4'(i), wdata: 16'h0};
      exp_q.push_back(op);
      op = '{rd: 1'b0, wr: 1'b1, addr: 4'(i), wdata: ~P};
      exp_q.push_back(op);
    end
    for (int i = N - 1; i >= 0; i--) begin
      op = '{rd: 1'b1, wr: 1'b0, addr: 4'(i), wdata: 16'h0};
      exp_q.push_back(op);
      op = '{rd: 1'b0, wr: 1'b1, addr: 4'(i), wdata: P};
      exp_q.push_back(op);
    end
    for (int i = 0; i < N; i++) begin
      op = '{rd: 1'b1, wr: 1'b0, addr: 4'(i), wdata: 16'h0};
      exp_q.push_back(op);
    end
    op = '{rd: 1'b0, wr: 1'b0, addr: 4'h0, wdata: 16'h0};  // drain cycle
    exp_q.push_back(op);
  endtask

  // One full run; start held for the first hold cycles of the busy period.
  task automatic run_and_check(input string name, input int hold, input logic exp_pass,
                               input int exp_cnt, input int exp_first, input bit alias_chk);
    op_t e;
    int  c;
    @(negedge clk);
    start = 1'b1;
    push_march();
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || pass !== 1'b0 || fail_count !== 8'd0 ||
        first_fail_addr !== 4'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s start_clear: got done=%b pass=%b cnt=%0d first=%0d busy=%b, want 0 0 0 0 1",
               name, done, pass, fail_count, first_fail_addr, busy);
    end
    c = 0;
    while (exp_q.size() > 0) begin
      start = (c < hold);
      e = exp_q.pop_front();
      n_vec++;
      if (bus.rd_en !== e.rd || bus.wr_en !== e.wr || busy !== 1'b1 ||
          ((e.rd || e.wr) && bus.addr !== e.addr) || (e.wr && bus.wdata !== e.wdata)) begin
        n_err++;
        $display("FAIL %s op%0d: got rd=%b wr=%b addr=%0d wdata=%h busy=%b, want rd=%b wr=%b addr=%0d wdata=%h busy=1",
                 name, c, bus.rd_en, bus.wr_en, bus.addr, bus.wdata, busy,
                 e.rd, e.wr, e.addr, e.wdata);
      end
      c++;
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_state: got done=%b busy=%b rd=%b wr=%b, want 1 0 0 0",
               name, done, busy, bus.rd_en, bus.wr_en);
    end
    n_vec++;
    if (alias_chk) begin
      if (pass !== 1'b0 || fail_count < 8'd1 ||
          (first_fail_addr !== 4'd3 && first_fail_addr !== 4'd11)) begin
        n_err++;
        $display("FAIL %s result: got pass=%b cnt=%0d first=%0d, want pass=0 cnt>=1 first in {3,11}",
                 name, pass, fail_count, first_fail_addr);
      end
    end else if (pass !== exp_pass || fail_count !== 8'(exp_cnt) ||
                 first_fail_addr !== 4'(exp_first)) begin
      n_err++;
      $display("FAIL %s result: got pass=%b cnt=%0d first=%0d, want pass=%b cnt=%0d first=%0d",
               name, pass, fail_count, first_fail_addr, exp_pass, exp_cnt, exp_first);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || excl_viol !== 0) begin
      n_err++;
      $display("FAIL %s hold_done: got done=%b busy=%b rd_wr_overlaps=%0d, want 1 0 0",
               name, done, busy, excl_viol);
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if (bus.addr !== 4'd0 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0 || bus.wdata !== 16'd0 ||
        busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail_count !== 8'd0 ||
        first_fail_addr !== 4'd0) begin
      n_err++;
      $display("FAIL reset: got addr=%0d rd=%b wr=%b wdata=%h busy=%b done=%b pass=%b cnt=%0d first=%0d, want all 0",
               bus.addr, bus.rd_en, bus.wr_en, bus.wdata, busy, done, pass, fail_count,
               first_fail_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fault_free();
    fault_mode = 0;
    run_and_check("fault_free", 0, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_stuck_at_1();
    fault_mode = 1;
    run_and_check("sa1_bit0_addr5", 0, 1'b0, 2, 5, 1'b0);
  endtask

  task automatic test_stuck_at_0();
    fault_mode = 2;
    run_and_check("sa0_bit15_addr9", 0, 1'b0, 1, 9, 1'b0);
  endtask

  task automatic test_abort();
    fault_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        fail_count !== 8'd0 || first_fail_addr !== 4'd0) begin
      n_err++;
      $display("FAIL abort_async: got rd=%b wr=%b busy=%b done=%b cnt=%0d first=%0d, want all 0",
               bus.rd_en, bus.wr_en, busy, done, fail_count, first_fail_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b done=%b rd=%b wr=%b, want 0 0 0 0",
               busy, done, bus.rd_en, bus.wr_en);
    end
    fault_mode = 0;
    run_and_check("after_abort", 0, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_start_hold();
    fault_mode = 1;
    run_and_check("start_held", 6 * N + 1, 1'b0, 2, 5, 1'b0);
    run_and_check("restart", 0, 1'b0, 2, 5, 1'b0);
  endtask

  task automatic test_alias();
    fault_mode = 3;
    run_and_check("alias_3_11", 0, 1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_at_1();
    test_stuck_at_0();
    test_abort();
    test_start_hold();
    test_alias();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
